// File: rtl/mano_timing_ctrl.sv
// rtl/mano_timing_ctrl.sv - Mano basic computer timing and control front-end
//
// Holds the instruction register, the 3-bit sequence counter and the RUN (S)
// flip-flop. Decodes T/D/I timing signals and requests memory during fetch
// and indirect cycles.
//
// Ports:
//   CLK        system clock, posedge
//   RST_N      asynchronous active-low reset
//   START      sets RUN when RUN=0
//   MEM_IN     memory data bus M[AR]
//   MEM_RDY    memory data valid this cycle
//   FETCH_REQ  memory read request (fetch or indirect)
//   IR_Q       instruction register
//   t          sequence counter value
//   T          one-hot decode of t
//   D          one-hot decode of IR_Q[14:12]
//   I          indirect bit IR_Q[15]
//   RUN        computer running
//   END_INST   last cycle of the current instruction
module mano_timing_ctrl #(
  parameter int WAIT_EN  = 1,
  parameter int BOOT_RUN = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [15:0] MEM_IN,
  input  logic        MEM_RDY,
  output logic        FETCH_REQ,
  output logic [15:0] IR_Q,
  output logic [2:0]  t,
  output logic [7:0]  T,
  output logic [7:0]  D,
  output logic        I,
  output logic        RUN,
  output logic        END_INST
);

  logic [2:0] sc;
  logic       mem_ok;
  logic       halt;
  logic       stall;

  assign t = sc;
  assign T = 8'b0000_0001 << sc;
  assign D = 8'b0000_0001 << IR_Q[14:12];
  assign I = IR_Q[15];

  // With waiting disabled the memory is assumed to answer every cycle.
  assign mem_ok = MEM_RDY | (WAIT_EN == 0);

  // Indirect operand fetch only for memory-reference opcodes (D7 is reg/IO).
  assign FETCH_REQ = RUN & (T[1] | (T[3] & ~D[7] & I));

  assign END_INST = RUN & ((D[7] & T[3])
                         | ((D[3] | D[4]) & T[4])
                         | ((D[0] | D[1] | D[2] | D[5]) & T[5])
                         | (D[6] & T[6]));

  assign halt  = RUN & D[7] & ~I & T[3] & IR_Q[0];
  assign stall = FETCH_REQ & ~mem_ok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sc   <= 3'd0;
      IR_Q <= 16'h0000;
      RUN  <= 1'(BOOT_RUN);
    end else if (!RUN) begin
      sc <= 3'd0;
      if (START) RUN <= 1'b1;
    end else begin
      if (halt) begin
        RUN <= 1'b0;
        sc  <= 3'd0;
      end else if (END_INST || sc == 3'd7) begin
        // t=7 is unreachable; recover to fetch if it ever appears.
        sc <= 3'd0;
      end else if (!stall) begin
        sc <= sc + 3'd1;
      end
      if (T[1] && mem_ok) IR_Q <= MEM_IN;
    end
  end

endmodule
